// File: rtl/team_02_uart_tx.sv
// Buffered 8N1 UART transmitter for one GPIO pin.
// Optional even-parity bit when TEAM_02_UART_TX_PARITY_EN is defined.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    transmit FIFO entries (power of 2, >= 2)
// Ports:
//   clk      system clock
//   nrst     async active-low reset
//   en       block enable; low flushes and releases the pin
//   wr_en    write strobe
//   wr_data  byte to queue
//   full     FIFO full (registered)
//   busy     frame in progress or FIFO non-empty
//   tx_out   serial line value
//   tx_oeb   active-low output enable
module team_02_uart_tx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       tx_out,
  output logic       tx_oeb
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TEAM_02_UART_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [2:0]      bit_q, bit_n;
  logic [7:0]      sh_q, sh_n;
`ifdef TEAM_02_UART_TX_PARITY_EN
  logic            par_q, par_n;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wptr_q, wptr_n;
  logic [AW:0]     rptr_q, rptr_n;
  logic            push, pop;
  logic            empty;
  logic            tc;
  logic [7:0]      head;

  logic            tx_d, busy_d;
  logic            full_d, oeb_d;

  assign empty = (wptr_q == rptr_q);
  assign head  = mem[rptr_q[AW-1:0]];
  assign tc    = (cnt_q == CMAX);
  // full is the registered status of
  // the current pointers, so a same-cycle
  // pop never frees room for a write.
  assign push  = wr_en && !full && en;

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
`ifdef TEAM_02_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      wptr_q  <= wptr_n;
      rptr_q  <= rptr_n;
`ifdef TEAM_02_UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr_q[AW-1:0]] <= wr_data;
  end

  // next-state logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    pop     = 1'b0;
`ifdef TEAM_02_UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    if (!en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      bit_n   = '0;
    end else begin
      if (state_q != S_IDLE)
        cnt_n = tc ? '0 : cnt_q + CW'(1);
      unique case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            sh_n    = head;
            cnt_n   = '0;
            bit_n   = '0;
            state_n = S_START;
`ifdef TEAM_02_UART_TX_PARITY_EN
            par_n   = ^head;
`endif
          end
        end
        S_START: begin
          if (tc)
            state_n = S_DATA;
        end
        S_DATA: begin
          if (tc) begin
            sh_n  = sh_q >> 1;
            bit_n = bit_q + 3'd1;
            if (bit_q == 3'd7)
`ifdef TEAM_02_UART_TX_PARITY_EN
              state_n = S_PAR;
`else
              state_n = S_STOP;
`endif
          end
        end
`ifdef TEAM_02_UART_TX_PARITY_EN
        S_PAR: begin
          if (tc)
            state_n = S_STOP;
        end
`endif
        S_STOP: begin
          if (tc) begin
            // chain the next frame with
            // no idle gap
            if (!empty) begin
              pop     = 1'b1;
              sh_n    = head;
              bit_n   = '0;
              state_n = S_START;
`ifdef TEAM_02_UART_TX_PARITY_EN
              par_n   = ^head;
`endif
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    if (!en) begin
      wptr_n = '0;
      rptr_n = '0;
    end else begin
      wptr_n = wptr_q + (AW+1)'(push);
      rptr_n = rptr_q + (AW+1)'(pop);
    end
  end

  // output logic, from next state so
  // the registered pins line up with it
  always_comb begin
    tx_d = 1'b1;
    unique case (state_n)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_n[0];
`ifdef TEAM_02_UART_TX_PARITY_EN
      S_PAR:   tx_d = par_n;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_n != S_IDLE) ||
             (wptr_n != rptr_n);
    full_d = (wptr_n[AW] != rptr_n[AW]) &&
             (wptr_n[AW-1:0] ==
              rptr_n[AW-1:0]);
    oeb_d  = !en;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_out <= 1'b1;
      tx_oeb <= 1'b1;
      full   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      tx_out <= tx_d;
      tx_oeb <= oeb_d;
      full   <= full_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_team_02_uart_tx.sv
// Testbench for team_02_uart_tx.
// Table vectors, corner sequences and a random stream.
module tb_team_02_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef TEAM_02_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, busy, tx_out, tx_oeb;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] rxq [$];
  logic [7:0] expq [$];
  bit mon_on = 1'b0;

  typedef struct {
    logic [7:0]  d;
    logic [10:0] frame;
  } vec_t;
  vec_t tbl [5];

  team_02_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .en(en),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .busy(busy),
    .tx_out(tx_out),
    .tx_oeb(tx_oeb)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h",
               n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // serial frame from the line rules:
  // start 0, data LSB first, [parity], stop 1
  function automatic logic [10:0] mk_frame(
      input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef TEAM_02_UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // line receiver: samples mid-bit
  always begin : mon
    logic [7:0] b;
    @(posedge clk);
    #1;
    if (mon_on && nrst && tx_out === 1'b0) begin
      repeat (CPB / 2) begin
        @(posedge clk);
        #1;
      end
      chk("rx start", tx_out, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) begin
          @(posedge clk);
          #1;
        end
        b[i] = tx_out;
      end
`ifdef TEAM_02_UART_TX_PARITY_EN
      repeat (CPB) begin
        @(posedge clk);
        #1;
      end
      chk("rx parity", tx_out, 32'(^b));
`endif
      repeat (CPB) begin
        @(posedge clk);
        #1;
      end
      chk("rx stop", tx_out, 1);
      rxq.push_back(b);
    end
  end

  task automatic send_vec(input vec_t v);
    wr_data = v.d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    chk($sformatf("queued busy %h", v.d), busy, 1);
    chk($sformatf("queued tx %h", v.d), tx_out, 1);
    step();
    for (int k = 0; k < NB * CPB; k++) begin
      chk($sformatf("tx %h k%0d", v.d, k),
          tx_out, 32'(v.frame[k / CPB]));
      chk($sformatf("busy %h k%0d", v.d, k),
          busy, 1);
      step();
    end
    chk($sformatf("end busy %h", v.d), busy, 0);
    chk($sformatf("end tx %h", v.d), tx_out, 1);
  endtask

  task automatic wait_idle(input string n);
    int g;
    g = 0;
    while (busy && g < 5000) begin
      step();
      g++;
    end
    chk({n, " idle timeout"}, busy, 0);
    repeat (3) step();
  endtask

  task automatic cmp_q(input string n);
    int m;
    chk({n, " count"}, rxq.size(), expq.size());
    m = rxq.size() < expq.size() ?
        rxq.size() : expq.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s byte %0d", n, i),
          rxq[i], expq[i]);
  endtask

  initial begin
    int cyc;
    int idx;
    int bad;
    logic [7:0] ds [5];
    ds = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h07};
    for (int i = 0; i < 5; i++) begin
      tbl[i].d = ds[i];
      tbl[i].frame = mk_frame(ds[i]);
    end

    // reset
    #2 nrst = 1'b0;
    repeat (2) step();
    chk("rst tx_out", tx_out, 1);
    chk("rst tx_oeb", tx_oeb, 1);
    chk("rst full", full, 0);
    chk("rst busy", busy, 0);
    en = 1'b1;
    step();
    chk("rst hold oeb", tx_oeb, 1);
    nrst = 1'b1;
    step();
    chk("oeb after release", tx_oeb, 0);
    chk("idle tx", tx_out, 1);
    step();

    // table vectors
    for (int i = 0; i < 5; i++)
      send_vec(tbl[i]);

    // FIFO full, back-to-back
    rxq.delete();
    expq.delete();
    mon_on = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h11 * (i + 1));
      wr_en = 1'b1;
      if (i < 5) expq.push_back(wr_data);
      step();
      cyc++;
      chk($sformatf("full after w%0d", i + 1),
          full, (i >= 4) ? 1 : 0);
    end
    wr_en = 1'b0;
    while (busy && cyc < 1000) begin
      step();
      cyc++;
    end
    chk("burst cycles", cyc, 2 + 5 * NB * CPB);
    repeat (3) step();
    cmp_q("burst");

    // pointer wrap-around
    rxq.delete();
    expq.delete();
    idx = 0;
    cyc = 0;
    while (idx < 12 && cyc < 3000) begin
      if (!full) begin
        wr_en = 1'b1;
        wr_data = 8'(idx);
        expq.push_back(wr_data);
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      cyc++;
    end
    wr_en = 1'b0;
    wait_idle("wrap");
    cmp_q("wrap");

    // random stream, writes also
    // attempted while full
    rxq.delete();
    expq.delete();
    idx = 0;
    cyc = 0;
    while (idx < 40 && cyc < 20000) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_en = 1'b0;
      end else begin
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        if (!full) begin
          expq.push_back(wr_data);
          idx++;
        end
      end
      step();
      cyc++;
    end
    wr_en = 1'b0;
    wait_idle("rand");
    cmp_q("rand");
    mon_on = 1'b0;

    // en drop during data bit 3
    wr_data = 8'hFF;
    wr_en = 1'b1;
    step();
    wr_data = 8'h12;
    step();
    wr_data = 8'h34;
    step();
    wr_en = 1'b0;
    repeat (16) step();
    chk("bit3 of FF", tx_out, 1);
    chk("bit3 busy", busy, 1);
    en = 1'b0;
    step();
    chk("en drop tx", tx_out, 1);
    chk("en drop oeb", tx_oeb, 1);
    chk("en drop busy", busy, 0);
    chk("en drop full", full, 0);
    repeat (3) step();
    en = 1'b1;
    step();
    chk("re-en oeb", tx_oeb, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_out !== 1'b1 || busy !== 1'b0)
        bad++;
      step();
    end
    chk("no frame after re-en", bad, 0);

    // reset mid-START
    wr_data = 8'h3C;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    step();
    chk("in start", tx_out, 0);
    #1 nrst = 1'b0;
    #1;
    chk("async rst tx", tx_out, 1);
    chk("async rst oeb", tx_oeb, 1);
    chk("async rst full", full, 0);
    chk("async rst busy", busy, 0);
    @(posedge clk);
    #1 nrst = 1'b1;
    step();
    chk("oeb after rst", tx_oeb, 0);
    chk("idle after rst", busy, 0);
    send_vec(tbl[3]);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
